// File: rtl/garuda_act_pkg.sv
// Shared types and constants for the activation ping/pong bank controller.
package garuda_act_pkg;

  localparam int ACT_DEPTH_DEF = 16384;
  localparam int CNT_W_DEF     = $clog2(ACT_DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } act_bank_state_e;

  typedef logic [CNT_W_DEF-1:0] act_tile_len_t;

  localparam logic BANK_PING = 1'b0;
  localparam logic BANK_PONG = 1'b1;

endpackage

// File: rtl/act_bank_fsm.sv
// Occupancy state of one activation bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module act_bank_fsm
  import garuda_act_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            fill_start,
  input  logic            fill_last,
  input  logic            take,
  input  logic            release_req,
  output act_bank_state_e state
);

  // Bank state register; flush overrides every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (fill_last) state <= FULL;
          else if (fill_start) state <= FILLING;
          else state <= EMPTY;
        end
        FILLING: begin
          if (fill_last) state <= FULL;
          else state <= FILLING;
        end
        FULL: begin
          if (take) state <= DRAINING;
          else state <= FULL;
        end
        DRAINING: begin
          if (release_req) state <= EMPTY;
          else state <= DRAINING;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/act_pingpong_ctrl.sv
// Ping/pong activation bank sequencer between the DMA fill path and the compute drain path.
module act_pingpong_ctrl
  import garuda_act_pkg::*;
#(
  parameter int ACT_DEPTH = ACT_DEPTH_DEF,
  parameter int CNT_W     = $clog2(ACT_DEPTH) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_valid_i,
  input  logic [CNT_W-1:0]             cfg_tile_words_i,
  output logic                         cfg_ready_o,
  output logic                         cfg_err_o,
  input  logic                         flush_i,
  input  logic                         dma_wr_valid_i,
  output logic                         dma_wr_ready_o,
  output logic                         dma_wr_bank_o,
  output logic [$clog2(ACT_DEPTH)-1:0] dma_wr_addr_o,
  output logic                         cmp_tile_valid_o,
  input  logic                         cmp_tile_ready_i,
  output logic                         cmp_tile_bank_o,
  input  logic                         cmp_release_i,
  output logic                         ping_pong_sel_o,
  output logic                         ping_pong_swap_o,
  output logic [1:0]                   bank_full_o,
  output logic                         idle_o,
  output logic                         proto_err_o
);

  localparam int               ADDR_W    = $clog2(ACT_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_LEN = CNT_W'(ACT_DEPTH);
  localparam logic [CNT_W-1:0] ONE_LEN   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_LEN  = {CNT_W{1'b0}};

  logic             fill_ptr_r;
  logic             drain_ptr_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [CNT_W-1:0] tile_words_r;
  logic             configured_r;
  logic             proto_err_r;
  logic             swap_r;
  logic             cfg_err_r;

  act_bank_state_e  bank_state [2];
  act_bank_state_e  fill_state_s;
  act_bank_state_e  drain_state_s;
  logic [1:0]       fill_hit_s;
  logic [1:0]       drain_hit_s;
  logic             beat_acc_s;
  logic             last_beat_s;
  logic             take_s;
  logic             release_ok_s;
  logic             release_bad_s;
  logic             idle_s;
  logic             cfg_legal_s;
  logic             cfg_accept_s;

  assign fill_state_s  = bank_state[fill_ptr_r];
  assign drain_state_s = bank_state[drain_ptr_r];
  assign fill_hit_s    = {fill_ptr_r == BANK_PONG, fill_ptr_r == BANK_PING};
  assign drain_hit_s   = {drain_ptr_r == BANK_PONG, drain_ptr_r == BANK_PING};

  assign dma_wr_ready_o = configured_r && ((fill_state_s == EMPTY) || (fill_state_s == FILLING));
  assign beat_acc_s     = dma_wr_valid_i && dma_wr_ready_o;
  assign last_beat_s    = beat_acc_s && (beat_cnt_r == (tile_words_r - ONE_LEN));
  assign take_s         = cmp_tile_valid_o && cmp_tile_ready_i;
  assign release_ok_s   = cmp_release_i && (drain_state_s == DRAINING);
  assign release_bad_s  = cmp_release_i && (drain_state_s != DRAINING);

  // idle is forced low while reset is held so every output reads 0 under reset.
  assign idle_s       = rst_ni && (bank_state[0] == EMPTY) && (bank_state[1] == EMPTY)
                        && (beat_cnt_r == ZERO_LEN);
  assign cfg_legal_s  = (cfg_tile_words_i != ZERO_LEN) && (cfg_tile_words_i <= DEPTH_LEN);
  assign cfg_accept_s = cfg_valid_i && idle_s && cfg_legal_s && !flush_i;

  act_bank_fsm u_bank_ping (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .flush       (flush_i),
    .fill_start  (beat_acc_s && fill_hit_s[0]),
    .fill_last   (last_beat_s && fill_hit_s[0]),
    .take        (take_s && drain_hit_s[0]),
    .release_req (release_ok_s && drain_hit_s[0]),
    .state       (bank_state[0])
  );

  act_bank_fsm u_bank_pong (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .flush       (flush_i),
    .fill_start  (beat_acc_s && fill_hit_s[1]),
    .fill_last   (last_beat_s && fill_hit_s[1]),
    .take        (take_s && drain_hit_s[1]),
    .release_req (release_ok_s && drain_hit_s[1]),
    .state       (bank_state[1])
  );

  // Pointers, beat counter, configuration and error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_ptr_r   <= BANK_PING;
      drain_ptr_r  <= BANK_PING;
      beat_cnt_r   <= ZERO_LEN;
      tile_words_r <= ZERO_LEN;
      configured_r <= 1'b0;
      proto_err_r  <= 1'b0;
      swap_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else if (flush_i) begin
      fill_ptr_r   <= BANK_PING;
      drain_ptr_r  <= BANK_PING;
      beat_cnt_r   <= ZERO_LEN;
      proto_err_r  <= 1'b0;
      swap_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      if (cfg_accept_s) begin
        tile_words_r <= cfg_tile_words_i;
        configured_r <= 1'b1;
      end
      cfg_err_r <= cfg_valid_i && idle_s && !cfg_legal_s;
      if ((cfg_valid_i && !idle_s) || release_bad_s) begin
        proto_err_r <= 1'b1;
      end
      if (last_beat_s) begin
        beat_cnt_r <= ZERO_LEN;
        fill_ptr_r <= ~fill_ptr_r;
      end else if (beat_acc_s) begin
        beat_cnt_r <= beat_cnt_r + ONE_LEN;
      end
      if (release_ok_s) begin
        drain_ptr_r <= ~drain_ptr_r;
      end
      swap_r <= release_ok_s;
    end
  end

  assign cfg_ready_o      = cfg_accept_s;
  assign cfg_err_o        = cfg_err_r;
  assign dma_wr_bank_o    = fill_ptr_r;
  assign dma_wr_addr_o    = beat_cnt_r[ADDR_W-1:0];
  assign cmp_tile_valid_o = (drain_state_s == FULL);
  assign cmp_tile_bank_o  = drain_ptr_r;
  assign ping_pong_sel_o  = drain_ptr_r;
  assign ping_pong_swap_o = swap_r;
  assign bank_full_o      = {bank_state[1] == FULL, bank_state[0] == FULL};
  assign idle_o           = idle_s;
  assign proto_err_o      = proto_err_r;

endmodule

// File: tb/tb_act_pingpong_ctrl.sv
// Randomized bench for act_pingpong_ctrl against a word-count based bank model.
module tb_act_pingpong_ctrl;
  import garuda_act_pkg::*;

  localparam int DEPTH = 16384;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cfg_valid_i = 1'b0;
  act_tile_len_t cfg_tile_words_i = '0;
  logic          cfg_ready_o, cfg_err_o;
  logic          flush_i = 1'b0;
  logic          dma_wr_valid_i = 1'b0;
  logic          dma_wr_ready_o, dma_wr_bank_o;
  logic [AW-1:0] dma_wr_addr_o;
  logic          cmp_tile_valid_o, cmp_tile_bank_o;
  logic          cmp_tile_ready_i = 1'b0;
  logic          cmp_release_i = 1'b0;
  logic          ping_pong_sel_o, ping_pong_swap_o;
  logic [1:0]    bank_full_o;
  logic          idle_o, proto_err_o;

  always #5 clk_i = ~clk_i;

  act_pingpong_ctrl #(.ACT_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_tile_words_i(cfg_tile_words_i),
    .cfg_ready_o(cfg_ready_o), .cfg_err_o(cfg_err_o), .flush_i(flush_i),
    .dma_wr_valid_i(dma_wr_valid_i), .dma_wr_ready_o(dma_wr_ready_o),
    .dma_wr_bank_o(dma_wr_bank_o), .dma_wr_addr_o(dma_wr_addr_o),
    .cmp_tile_valid_o(cmp_tile_valid_o), .cmp_tile_ready_i(cmp_tile_ready_i),
    .cmp_tile_bank_o(cmp_tile_bank_o), .cmp_release_i(cmp_release_i),
    .ping_pong_sel_o(ping_pong_sel_o), .ping_pong_swap_o(ping_pong_swap_o),
    .bank_full_o(bank_full_o), .idle_o(idle_o), .proto_err_o(proto_err_o)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Model: each bank is described by how many words it holds and whether compute has taken it.
  int m_len, m_fb, m_db;
  int m_words [2];
  bit m_taken [2];
  bit m_cfgd, m_perr, m_swap, m_cfg_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_full(input int b);
    return (m_words[b] > 0) && (m_words[b] == m_len) && !m_taken[b];
  endfunction

  function automatic bit m_open(input int b);
    return m_cfgd && (m_words[b] < m_len);
  endfunction

  function automatic bit m_idle();
    return (m_words[0] == 0) && (m_words[1] == 0);
  endfunction

  task automatic m_reset();
    m_len = 0; m_fb = 0; m_db = 0; m_cfgd = 1'b0;
    m_perr = 1'b0; m_swap = 1'b0; m_cfg_err = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_words[b] = 0;
      m_taken[b] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {cfg_ready_o, cfg_err_o, dma_wr_ready_o, dma_wr_bank_o, dma_wr_addr_o,
              cmp_tile_valid_o, cmp_tile_bank_o, ping_pong_sel_o, ping_pong_swap_o,
              bank_full_o, idle_o, proto_err_o}, 32'd0);
  endtask

  task automatic step(input bit cv, input int cw, input bit fl, input bit dv, input bit cr, input bit rl);
    bit acc, tk, idle_now, legal;
    int old_len, old_db;
    @(negedge clk_i);
    cfg_valid_i = cv; cfg_tile_words_i = CW'(cw); flush_i = fl;
    dma_wr_valid_i = dv; cmp_tile_ready_i = cr; cmp_release_i = rl;
    #1;
    legal = (cw >= 1) && (cw <= DEPTH);
    idle_now = m_idle();
    chk("cfg_ready", cfg_ready_o, cv && idle_now && legal);
    chk("cfg_err", cfg_err_o, m_cfg_err);
    chk("dma_ready", dma_wr_ready_o, m_open(m_fb));
    chk("dma_bank", dma_wr_bank_o, m_fb);
    chk("dma_addr", dma_wr_addr_o, (m_words[m_fb] < m_len) ? m_words[m_fb] : 0);
    chk("cmp_valid", cmp_tile_valid_o, m_full(m_db));
    chk("cmp_bank", cmp_tile_bank_o, m_db);
    chk("pp_sel", ping_pong_sel_o, m_db);
    chk("pp_swap", ping_pong_swap_o, m_swap);
    chk("bank_full", bank_full_o, {m_full(1), m_full(0)});
    chk("idle", idle_o, idle_now);
    chk("proto_err", proto_err_o, m_perr);
    old_len = m_len; old_db = m_db;
    acc = dv && m_open(m_fb);
    tk  = cr && m_full(m_db);
    if (fl) begin
      m_fb = 0; m_db = 0; m_perr = 1'b0; m_swap = 1'b0; m_cfg_err = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_words[b] = 0;
        m_taken[b] = 1'b0;
      end
    end else begin
      m_cfg_err = cv && idle_now && !legal;
      if (cv && idle_now && legal) begin
        m_len = cw; m_cfgd = 1'b1;
      end
      if (cv && !idle_now) m_perr = 1'b1;
      m_swap = 1'b0;
      if (rl) begin
        if (m_taken[old_db]) begin
          m_words[old_db] = 0; m_taken[old_db] = 1'b0; m_db = 1 - old_db; m_swap = 1'b1;
        end else begin
          m_perr = 1'b1;
        end
      end
      if (tk) m_taken[old_db] = 1'b1;
      if (acc) begin
        m_words[m_fb]++;
        if (m_words[m_fb] == old_len) m_fb = 1 - m_fb;
      end
    end
  endtask

  task automatic hit_reset(input int cycles);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    cfg_valid_i = 1'b1; cfg_tile_words_i = CW'(4); flush_i = 1'b0;
    dma_wr_valid_i = 1'b1; cmp_tile_ready_i = 1'b1; cmp_release_i = 1'b1;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i);
      #1;
      check_zero("rst_hold");
    end
    m_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    cfg_valid_i = 1'b0; dma_wr_valid_i = 1'b0; cmp_tile_ready_i = 1'b0; cmp_release_i = 1'b0;
  endtask

  initial begin
    bit cv, fl, dv, cr, rl;
    int cw, r;
    m_reset();
    cfg_valid_i = 1'b1; cfg_tile_words_i = CW'(4);
    #3;
    check_zero("por");
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("por_hold");
    @(negedge clk_i);
    rst_ni = 1'b1; cfg_valid_i = 1'b0;

    // Directed walk through the main scenarios.
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, DEPTH + 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, DEPTH, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    repeat (9) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1);
    repeat (2) step(0, 0, 0, 1, 0, 0);

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      cv = ($urandom_range(0, 39) == 0);
      fl = !cv && ($urandom_range(0, 59) == 0);
      r  = $urandom_range(0, 11);
      cw = (r == 0) ? 0 : (r == 1) ? DEPTH + 1 : (r == 2) ? DEPTH : $urandom_range(1, 5);
      dv = !cv && ($urandom_range(0, 3) != 0);
      cr = $urandom_range(0, 1);
      rl = m_taken[m_db] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      step(cv, cw, fl, dv, cr, rl);
    end

    // Reset in the middle of a drain, then restart from scratch.
    step(0, 0, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    hit_reset(2);
    step(0, 0, 0, 1, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
